// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shared word-addressed data RAM for the main core (port 0) and NUM_SUB subcores.
// Round-robin grant, registered 1-cycle ack/rdata; define DATA_MEM_ARB_MAIN_PRIO_EN to give port 0 priority.
module data_mem_arbiter #(
  parameter int unsigned NUM_SUB = 1,
  parameter int unsigned DEPTH   = 120000,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_SUB:0]              req,
  input  logic [(NUM_SUB+1)*AW-1:0]     addr,
  input  logic [(NUM_SUB+1)*DW-1:0]     din,
  input  logic [(NUM_SUB+1)*(DW/8)-1:0] we,
  output logic [NUM_SUB:0]              gnt,
  output logic [NUM_SUB:0]              ack,
  output logic [DW-1:0]                 rdata,
  output logic                          err
);
  localparam int unsigned N  = NUM_SUB + 1;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NS = (N > 1) ? N - 1 : 1;

  logic [PW-1:0] gidx;
  logic          gany;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_din;
  logic [BW-1:0] sel_we;
  logic          sel_oor;
  logic          sel_rd;
  logic [DW-1:0] mem [DEPTH];

`ifdef DATA_MEM_ARB_MAIN_PRIO_EN
  // Subcore-only pointer, held as an offset from port 1
  logic [PW-1:0] sptr;

  always_comb begin : arb
    int unsigned k;
    k    = 0;
    gidx = '0;
    gany = 1'b0;
    if (rstn && req[0]) begin
      gany = 1'b1;
    end else if (rstn) begin
      for (int unsigned j = 0; j < NS; j++) begin
        k = 1 + ((32'(sptr) + j) % NS);
        if (!gany && (k < N) && req[k]) begin
          gany = 1'b1;
          gidx = PW'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin : ptr_reg
    if (!rstn) begin
      sptr <= '0;
    end else if (gany && (gidx != '0)) begin
      sptr <= PW'(32'(gidx) % NS);
    end
  end
`else
  logic [PW-1:0] ptr;

  // First requester at or after the pointer, wrapping modulo N
  always_comb begin : arb
    int unsigned k;
    k    = 0;
    gidx = '0;
    gany = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      k = (32'(ptr) + j) % N;
      if (rstn && !gany && req[k]) begin
        gany = 1'b1;
        gidx = PW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin : ptr_reg
    if (!rstn) begin
      ptr <= '0;
    end else if (gany) begin
      ptr <= PW'((32'(gidx) + 1) % N);
    end
  end
`endif

  always_comb begin : gnt_dec
    gnt = '0;
    if (gany) gnt[gidx] = 1'b1;
  end

  assign sel_addr = addr[32'(gidx)*AW +: AW];
  assign sel_din  = din[32'(gidx)*DW +: DW];
  assign sel_we   = we[32'(gidx)*BW +: BW];
  assign sel_oor  = (sel_addr >= AW'(DEPTH));
  assign sel_rd   = (sel_we == '0);

  // RAM is never reset; out-of-range writes are dropped
  always_ff @(posedge clk) begin : ram_wr
    if (gany && !sel_oor) begin
      for (int b = 0; b < int'(BW); b++) begin
        if (sel_we[b]) mem[IW'(sel_addr)][b*8 +: 8] <= sel_din[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin : out_reg
    if (!rstn) begin
      ack   <= '0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= gnt;
      err <= gany && sel_oor;
      if (gany && sel_rd) rdata <= sel_oor ? '0 : mem[IW'(sel_addr)];
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized and directed checks of data_mem_arbiter (NUM_SUB=3)
// against a queue/array reference model; honours DATA_MEM_ARB_MAIN_PRIO_EN.
module tb_data_mem_arbiter;
  localparam int unsigned NUM_SUB = 3;
  localparam int unsigned N       = NUM_SUB + 1;
  localparam int unsigned DEPTH   = 120000;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   treq;
  logic [31:0]  ta   [4];
  logic [31:0]  tdin [4];
  logic [3:0]   twe  [4];
  logic [127:0] addr_bus;
  logic [127:0] din_bus;
  logic [15:0]  we_bus;
  logic [3:0]   gnt;
  logic [3:0]   ack;
  logic [31:0]  rdata;
  logic         err;

  int total;
  int bad;

  // Reference model state
  int           m_ptr;
  int           m_sptr;
  logic [31:0]  m_rd;
  bit           m_rd_known;
  logic [31:0]  mdl [int];

  always #5 clk = ~clk;

  for (genvar p = 0; p < 4; p++) begin : g_pack
    assign addr_bus[p*32 +: 32] = ta[p];
    assign din_bus[p*32 +: 32]  = tdin[p];
    assign we_bus[p*4 +: 4]     = twe[p];
  end

  data_mem_arbiter #(.NUM_SUB(NUM_SUB), .DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rstn(rstn), .req(treq), .addr(addr_bus), .din(din_bus), .we(we_bus),
    .gnt(gnt), .ack(ack), .rdata(rdata), .err(err)
  );

  function automatic int pick(input logic [3:0] r);
`ifdef DATA_MEM_ARB_MAIN_PRIO_EN
    if (r[0]) return 0;
    for (int j = 0; j < 3; j++) if (r[1 + (m_sptr + j) % 3]) return 1 + (m_sptr + j) % 3;
`else
    for (int j = 0; j < 4; j++) if (r[(m_ptr + j) % 4]) return (m_ptr + j) % 4;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_sptr = 0; m_rd = 32'h0; m_rd_known = 1'b1;
  endtask

  // Apply the current request set to the model; returns expected grant and err
  task automatic model_cycle(output logic [3:0] eg, output logic eerr);
    int k;
    logic [31:0] a;
    logic [31:0] word;
    k = pick(treq);
    eg = 4'b0; eerr = 1'b0;
    if (k < 0) return;
    eg[k] = 1'b1;
    a = ta[k];
    eerr = (a >= DEPTH);
`ifdef DATA_MEM_ARB_MAIN_PRIO_EN
    if (k != 0) m_sptr = k % 3;
`else
    m_ptr = (k + 1) % 4;
`endif
    if (twe[k] != 4'b0) begin
      if (!eerr) begin
        word = mdl.exists(int'(a)) ? mdl[int'(a)] : 32'h0;
        for (int b = 0; b < 4; b++) if (twe[k][b]) word[b*8 +: 8] = tdin[k][b*8 +: 8];
        mdl[int'(a)] = word;
      end
    end else if (eerr) begin
      m_rd = 32'h0; m_rd_known = 1'b1;
    end else if (mdl.exists(int'(a))) begin
      m_rd = mdl[int'(a)]; m_rd_known = 1'b1;
    end else begin
      m_rd_known = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    treq = 4'b0;
    for (int p = 0; p < 4; p++) begin ta[p] = 32'h0; tdin[p] = 32'h0; twe[p] = 4'h0; end
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    treq[p] = 1'b1; ta[p] = a; tdin[p] = d; twe[p] = w;
  endtask

  // Called at a negedge with inputs driven; samples gnt, then the registered outputs
  task automatic tick(output logic [3:0] og, output logic [3:0] oa, output logic [31:0] ord, output logic oe);
    #1 og = gnt;
    @(posedge clk); #1;
    oa = ack; ord = rdata; oe = err;
    @(negedge clk);
  endtask

  task automatic directed_step(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                               output logic [3:0] eg, output logic eerr,
                               output logic [3:0] og, output logic [3:0] oa, output logic [31:0] ord, output logic oe);
    clear_inputs();
    set_port(p, a, d, w);
    model_cycle(eg, eerr);
    tick(og, oa, ord, oe);
  endtask

  task automatic test_reset();
    #1;
    if ({gnt, ack, err, rdata} !== 41'h0) begin
      bad++; $display("FAIL reset_async outs got=%h exp=0", {gnt, ack, err, rdata});
    end
    total++;
    treq = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    if ({gnt, ack, err, rdata} !== 41'h0) begin
      bad++; $display("FAIL reset_hold outs got=%h exp=0", {gnt, ack, err, rdata});
    end
    total++;
    @(negedge clk);
    clear_inputs();
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_single_port();
    int          pp [2] = '{0, 0};
    logic [31:0] aa [2] = '{32'd5, 32'd5};
    logic [31:0] dd [2] = '{32'hDEADBEEF, 32'h0};
    logic [3:0]  ww [2] = '{4'hF, 4'h0};
    logic [3:0] eg, og, oa; logic eerr, oe; logic [31:0] ord;
    for (int i = 0; i < 2; i++) begin
      directed_step(pp[i], aa[i], dd[i], ww[i], eg, eerr, og, oa, ord, oe);
      if (og !== 4'b0001) begin bad++; $display("FAIL single[%0d] gnt got=%b exp=0001", i, og); end
      if (oa !== 4'b0001) begin bad++; $display("FAIL single[%0d] ack got=%b exp=0001", i, oa); end
      if (oe !== 1'b0)    begin bad++; $display("FAIL single[%0d] err got=%b exp=0", i, oe); end
      total += 3;
    end
    if (ord !== 32'hDEADBEEF) begin bad++; $display("FAIL single_read rdata got=%h exp=deadbeef", ord); end
    total++;
  endtask

  task automatic test_byte_enable();
    int          pp [3] = '{2, 3, 1};
    logic [31:0] dd [3] = '{32'h11223344, 32'hAABBCCDD, 32'h0};
    logic [3:0]  ww [3] = '{4'hF, 4'b0101, 4'h0};
    logic [3:0] eg, og, oa; logic eerr, oe; logic [31:0] ord;
    for (int i = 0; i < 3; i++) begin
      directed_step(pp[i], 32'd7, dd[i], ww[i], eg, eerr, og, oa, ord, oe);
      if (og !== eg)   begin bad++; $display("FAIL byte_en[%0d] gnt got=%b exp=%b", i, og, eg); end
      if (oa !== eg)   begin bad++; $display("FAIL byte_en[%0d] ack got=%b exp=%b", i, oa, eg); end
      if (oe !== eerr) begin bad++; $display("FAIL byte_en[%0d] err got=%b exp=%b", i, oe, eerr); end
      total += 3;
    end
    if (ord !== 32'h11BB33DD) begin bad++; $display("FAIL byte_en rdata got=%h exp=11bb33dd", ord); end
    total++;
  endtask

  task automatic test_out_of_range();
    int          pp [7] = '{0, 1, 2, 0, 3, 3, 1};
    logic [31:0] aa [7] = '{32'd0, 32'd120000, 32'd120000, 32'd0, 32'd119999, 32'd119999, 32'hFFFFFFFF};
    logic [31:0] dd [7] = '{32'hCAFEF00D, 32'h0, 32'h12345678, 32'h0, 32'h0A0B0C0D, 32'h0, 32'h0};
    logic [3:0]  ww [7] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0};
    logic        xe [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] eg, og, oa; logic eerr, oe; logic [31:0] ord;
    for (int i = 0; i < 7; i++) begin
      directed_step(pp[i], aa[i], dd[i], ww[i], eg, eerr, og, oa, ord, oe);
      if (og !== eg)    begin bad++; $display("FAIL oor[%0d] gnt got=%b exp=%b", i, og, eg); end
      if (oa !== eg)    begin bad++; $display("FAIL oor[%0d] ack got=%b exp=%b", i, oa, eg); end
      if (oe !== xe[i]) begin bad++; $display("FAIL oor[%0d] err got=%b exp=%b", i, oe, xe[i]); end
      if (ord !== m_rd) begin bad++; $display("FAIL oor[%0d] rdata got=%h exp=%h", i, ord, m_rd); end
      total += 4;
      if (i == 3 && ord !== 32'hCAFEF00D) begin
        bad++; $display("FAIL oor_no_write rdata got=%h exp=cafef00d", ord);
      end
      if (i == 3) total++;
    end
  endtask

  task automatic test_raw_cross_port();
    logic [3:0] eg, og, oa; logic eerr, oe; logic [31:0] ord;
    directed_step(1, 32'd9, 32'h5, 4'hF, eg, eerr, og, oa, ord, oe);
    if (oa !== 4'b0010) begin bad++; $display("FAIL raw_wr ack got=%b exp=0010", oa); end
    directed_step(0, 32'd9, 32'h0, 4'h0, eg, eerr, og, oa, ord, oe);
    if (oa !== 4'b0001)  begin bad++; $display("FAIL raw_rd ack got=%b exp=0001", oa); end
    if (ord !== 32'h5)   begin bad++; $display("FAIL raw_rd rdata got=%h exp=5", ord); end
    total += 3;
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] eg, og, oa; logic eerr, oe; logic [31:0] ord;
    directed_step(1, 32'd5, 32'h0, 4'h0, eg, eerr, og, oa, ord, oe);
    if (ord !== 32'hDEADBEEF) begin bad++; $display("FAIL midrst_pre rdata got=%h exp=deadbeef", ord); end
    total++;
    clear_inputs();
    set_port(2, 32'd7, 32'h0, 4'h0);
    #1;
    if (gnt !== 4'b0100) begin bad++; $display("FAIL midrst gnt got=%b exp=0100", gnt); end
    total++;
    #1 rstn = 1'b0;
    #1;
    if ({gnt, ack, err, rdata} !== 41'h0) begin
      bad++; $display("FAIL midrst_async outs got=%h exp=0", {gnt, ack, err, rdata});
    end
    @(posedge clk); #1;
    if ({gnt, ack, err, rdata} !== 41'h0) begin
      bad++; $display("FAIL midrst_edge outs got=%h exp=0", {gnt, ack, err, rdata});
    end
    total += 2;
    @(negedge clk);
    clear_inputs();
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_fairness();
    logic [31:0] ra [4] = '{32'd5, 32'd7, 32'd9, 32'd0};
    logic [3:0] eg, og, oa, xg; logic eerr, oe; logic [31:0] ord;
    clear_inputs();
    for (int p = 0; p < 4; p++) set_port(p, ra[p], 32'h0, 4'h0);
    for (int c = 0; c < 8; c++) begin
`ifdef DATA_MEM_ARB_MAIN_PRIO_EN
      xg = 4'b0001;
`else
      xg = 4'b0001 << (c % 4);
`endif
      model_cycle(eg, eerr);
      tick(og, oa, ord, oe);
      if (og !== xg)    begin bad++; $display("FAIL fair[%0d] gnt got=%b exp=%b", c, og, xg); end
      if (oa !== xg)    begin bad++; $display("FAIL fair[%0d] ack got=%b exp=%b", c, oa, xg); end
      if (ord !== m_rd) begin bad++; $display("FAIL fair[%0d] rdata got=%h exp=%h", c, ord, m_rd); end
      total += 3;
    end
  endtask

  task automatic test_random();
    int wait_c [4];
    int r;
    logic [31:0] a;
    logic [3:0] w, eg, og, oa; logic eerr, oe; logic [31:0] ord;
    logic [3:0] eg_i, og_i, oa_i; logic eerr_i, oe_i; logic [31:0] ord_i;
    for (int i = 0; i < 16; i++) begin
      directed_step(i % 4, 32'(i), $urandom, 4'hF, eg_i, eerr_i, og_i, oa_i, ord_i, oe_i);
      if (oa_i !== eg_i) begin bad++; $display("FAIL fill[%0d] ack got=%b exp=%b", i, oa_i, eg_i); end
      total++;
    end
    clear_inputs();
    for (int p = 0; p < 4; p++) wait_c[p] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < 4; p++) begin
        if (!treq[p] && $urandom_range(0, 1) == 1) begin
          r = int'($urandom_range(0, 9));
          a = (r == 0) ? DEPTH + $urandom_range(0, 3) : (r == 1) ? DEPTH - 1 : $urandom_range(0, 15);
          w = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
          set_port(p, a, $urandom, w);
          wait_c[p] = 0;
        end
      end
      model_cycle(eg, eerr);
      tick(og, oa, ord, oe);
      if (og !== eg)   begin bad++; $display("FAIL rand[%0d] gnt got=%b exp=%b", c, og, eg); end
      if (oa !== eg)   begin bad++; $display("FAIL rand[%0d] ack got=%b exp=%b", c, oa, eg); end
      if (oe !== eerr) begin bad++; $display("FAIL rand[%0d] err got=%b exp=%b", c, oe, eerr); end
      total += 3;
      if (m_rd_known) begin
        if (ord !== m_rd) begin bad++; $display("FAIL rand[%0d] rdata got=%h exp=%h", c, ord, m_rd); end
        total++;
      end
      for (int p = 0; p < 4; p++) begin
        if (treq[p]) begin
          wait_c[p]++;
          if (eg[p]) treq[p] = 1'b0;
`ifndef DATA_MEM_ARB_MAIN_PRIO_EN
          else begin
            if (wait_c[p] >= int'(N)) begin
              bad++; $display("FAIL rand[%0d] starve port=%0d waited=%0d max=%0d", c, p, wait_c[p], N - 1);
            end
            total++;
          end
`endif
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b1;
    clear_inputs();
    model_reset();
    #3 rstn = 1'b0;
    test_reset();
    test_single_port();
    test_byte_enable();
    test_out_of_range();
    test_raw_cross_port();
    test_reset_mid_read();
    test_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shared data memory for the main core plus NUM_SUB subcores; generalises the single-port data memory interface (addr/din/4-bit byte we) to N requesters.
- Round-robin arbitration, one access per cycle, registered 1-cycle read/ack latency, out-of-range detection.
- Sits between the core LSUs (port 0 = main core, ports 1..NUM_SUB = subcores) and the on-chip data RAM.

Parameters:
- NUM_SUB, 1, number of subcores; total ports N = NUM_SUB+1
- DEPTH, 120000, memory depth in 32-bit words
- AW, 32, address width (word address)
- DW, 32, data width; byte enables DW/8

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req  in  N  per-port request, held until granted
- addr  in  N*AW  per-port word address, port i at [i*AW +: AW]
- din  in  N*DW  per-port write data
- we  in  N*DW/8  per-port byte write enables; all zero = read
- gnt  out  N  one-hot grant, combinational, same cycle as accepted req
- ack  out  N  one-hot completion, one cycle after gnt
- rdata  out  DW  read data, valid with ack for reads
- err  out  1  pulses with ack when granted addr >= DEPTH

Behaviour:
- Reset (async assert, sync release): ack=0, err=0, rdata=0, RR pointer=0. RAM contents not cleared and not touched.
- Arbitration: among asserted req, grant the first index at or after the pointer, wrapping modulo N. At most one gnt bit per cycle. gnt=0 when req=0.
- After a grant to port i, the pointer becomes (i+1) mod N on that edge. With no grant, the pointer holds.
- Access occurs on the clock edge where gnt is high:
  - Write (we!=0, addr<DEPTH): for each k with we[k]=1, byte k of mem[addr] is replaced by din byte k. Other bytes are unchanged.
  - Read (we==0, addr<DEPTH): mem[addr] is registered and driven on rdata.
- Latency: ack[i]=1 exactly one cycle after gnt[i]; single-cycle pulse.
  - Reads: rdata valid in the ack cycle and holds until the next read ack.
  - Writes: rdata is not updated.
- Out of range (addr >= DEPTH): no RAM write. Reads return rdata=0. err=1 in the ack cycle.
- Requester protocol: keep req/addr/din/we stable until gnt. Deassert or present a new request in the cycle after gnt. A req still high after gnt is treated as a new request.
- Back-to-back: one grant per cycle sustained.
  - Write then read to the same address by any ports in consecutive cycles: the read returns the written data.
  - Same-cycle read/write conflict is impossible (single grant).
- Starvation bound: a continuously asserted req is granted within N cycles.
- NUM_SUB=0 (N=1): arbiter degenerates to a pass-through; gnt=req.
- Reset asserted mid-operation: a pending ack is dropped, a write granted in the reset cycle is not guaranteed, and the pointer returns to 0.

Optional Feature:
- Macro: DATA_MEM_ARB_MAIN_PRIO_EN.
- Defined: port 0 (main core) wins whenever req[0]=1. Ports 1..N-1 are round-robin among themselves with their own pointer, updated only on subcore grants.
- Undefined: pure round-robin over all N ports as above.

Test Plan:
- Reset then single port: NUM_SUB=1.
  - Port 0 writes addr=5, din=0xDEADBEEF, we=4'b1111 -> gnt[0] same cycle, ack[0] next cycle, err=0.
  - Port 0 then reads addr=5 -> ack[0] with rdata=0xDEADBEEF.
- Byte enables: mem[7]=0x11223344, write din=0xAABBCCDD with we=4'b0101 -> read addr 7 returns 0x11BB33DD.
- Round-robin fairness: NUM_SUB=3, all four req held high for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3 and ack follows one cycle later.
- Out of range: read addr=120000 -> ack with err=1, rdata=0. Write addr=120000 -> err=1, and a later read of addr 0 is unchanged.
- Read-after-write, cross port: port 1 writes addr 9 = 0x5, then port 0 reads addr 9 in the next cycle -> rdata=0x5.
- Async reset mid-read and priority macro:
  - rstn low between gnt and ack -> ack stays 0, all outputs 0 while low. After release the pointer is 0.
  - With DATA_MEM_ARB_MAIN_PRIO_EN and all req high -> gnt[0] every cycle.
